// File: rtl/mem_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_pkg;

    localparam int DEPTH_DEF   = 16384;
    localparam int TIMEOUT_DEF = 15;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_e;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } owner_e;

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester and memory-side signals of the arbiter; slave is the arbiter's view.
interface mem_arbiter_if;

    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_rdata;
    logic        if_err;

    logic        d_req;
    logic        d_we;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_ack;
    logic [31:0] d_rdata;
    logic        d_err;

    logic        mem_w_enable;
    logic        mem_r_enable;
    logic [31:0] mem_address;
    logic [31:0] mem_word_in;
    logic [31:0] mem_word_out;
    logic        mem_rdy;

    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_word_out, mem_rdy,
        output if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        output mem_w_enable, mem_r_enable, mem_address, mem_word_in
    );

    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_word_out, mem_rdy,
        input  if_ack, if_rdata, if_err, d_ack, d_rdata, d_err,
        input  mem_w_enable, mem_r_enable, mem_address, mem_word_in
    );

endinterface

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-way round-robin grant; bit 0 = fetch, bit 1 = data. The flag moves only when a grant is taken.
module rr_arb2
    import mem_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       take_i,
    output logic [1:0] gnt_o
);

    owner_e last_q, last_d;

    always_comb begin
        gnt_o  = 2'b00;
        last_d = last_q;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = (last_q == GNT_IF) ? 2'b10 : 2'b01;
            default: gnt_o = 2'b00;
        endcase
        if (take_i && gnt_o[1]) begin
            last_d = GNT_D;
        end else if (take_i && gnt_o[0]) begin
            last_d = GNT_IF;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q <= GNT_IF;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-access memory.
//   state | meaning
//   IDLE  | wait for a request, grant and latch it
//   ISSUE | one-cycle enable pulse toward memory
//   WAIT  | wait for mem_rdy or timeout
//   RESP  | one-cycle ack to the granted requester
module mem_arbiter
    import mem_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input logic         clk,
    input logic         rst,
    mem_arbiter_if.slave bus
);

    localparam int CW = $clog2(TIMEOUT + 1);

    state_e         state_q, state_d;
    owner_e         owner_q, owner_d;
    logic           we_q, we_d;
    logic           err_q, err_d;
    logic [31:0]    addr_q, addr_d;
    logic [31:0]    wdata_q, wdata_d;
    logic [31:0]    if_rdata_q, if_rdata_d;
    logic [31:0]    d_rdata_q, d_rdata_d;
    logic [CW-1:0]  cnt_q, cnt_d, cnt_inc;
    logic [1:0]     gnt;
    logic           take;
    logic [31:0]    sel_addr;

    rr_arb2 u_rr_arb2 (
        .clk    (clk),
        .rst    (rst),
        .req_i  ({bus.d_req, bus.if_req}),
        .take_i (take),
        .gnt_o  (gnt)
    );

    assign sel_addr = gnt[1] ? bus.d_addr : bus.if_addr;
    assign cnt_inc  = (cnt_q == CW'(TIMEOUT)) ? cnt_q : cnt_q + CW'(1);

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        we_d             = we_q;
        err_d            = err_q;
        addr_d           = addr_q;
        wdata_d          = wdata_q;
        if_rdata_d       = if_rdata_q;
        d_rdata_d        = d_rdata_q;
        cnt_d            = cnt_q;
        take             = 1'b0;
        bus.mem_w_enable = 1'b0;
        bus.mem_r_enable = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (gnt != 2'b00) begin
                    take    = 1'b1;
                    owner_d = gnt[1] ? GNT_D : GNT_IF;
                    we_d    = gnt[1] & bus.d_we;
                    addr_d  = sel_addr;
                    wdata_d = gnt[1] ? bus.d_wdata : 32'd0;
                    cnt_d   = '0;
                    // Out-of-range addresses are answered without touching memory.
                    if (sel_addr >= 32'(DEPTH)) begin
                        err_d   = 1'b1;
                        state_d = ST_RESP;
                    end else begin
                        err_d   = 1'b0;
                        state_d = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                bus.mem_w_enable = we_q;
                bus.mem_r_enable = ~we_q;
                cnt_d            = '0;
                state_d          = ST_WAIT;
            end
            ST_WAIT: begin
                cnt_d = cnt_inc;
                if (bus.mem_rdy) begin
                    err_d   = 1'b0;
                    state_d = ST_RESP;
                    if (!we_q && owner_q == GNT_IF) if_rdata_d = bus.mem_word_out;
                    if (!we_q && owner_q == GNT_D)  d_rdata_d  = bus.mem_word_out;
                end else if (cnt_inc == CW'(TIMEOUT)) begin
                    err_d   = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= GNT_IF;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            we_q       <= we_d;
            err_q      <= err_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            cnt_q      <= cnt_d;
        end
    end

    assign bus.if_ack      = (state_q == ST_RESP) && (owner_q == GNT_IF);
    assign bus.d_ack       = (state_q == ST_RESP) && (owner_q == GNT_D);
    assign bus.if_err      = bus.if_ack & err_q;
    assign bus.d_err       = bus.d_ack & err_q;
    assign bus.if_rdata    = if_rdata_q;
    assign bus.d_rdata     = d_rdata_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_word_in = wdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a small latency-programmable memory model.
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_arbiter_if bus ();

    mem_arbiter u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    // memory model: busy for mem_lat cycles after each enable, preloaded on reset
    logic [31:0] mem [0:255];
    int mem_lat = 0;
    int busy = 0;
    assign bus.mem_rdy = (busy == 0);

    always @(posedge clk) begin
        if (rst) mem[5] <= 32'hDEADBEEF;
        if (bus.mem_w_enable) mem[bus.mem_address[7:0]] <= bus.mem_word_in;
        if (bus.mem_r_enable) bus.mem_word_out <= mem[bus.mem_address[7:0]];
        if (bus.mem_w_enable || bus.mem_r_enable) busy <= mem_lat;
        else if (busy > 0) busy <= busy - 1;
    end

    int overlap_cnt = 0, wen_cnt = 0, en_cnt = 0, if_ack_cnt = 0, d_ack_cnt = 0;
    always @(negedge clk) begin
        if (bus.mem_w_enable && bus.mem_r_enable) overlap_cnt++;
        if (bus.if_ack && bus.d_ack) overlap_cnt++;
        if (bus.mem_w_enable) wen_cnt++;
        if (bus.mem_w_enable || bus.mem_r_enable) en_cnt++;
        if (bus.if_ack) if_ack_cnt++;
        if (bus.d_ack) d_ack_cnt++;
    end

    task automatic access(input bit port, input bit we, input logic [31:0] addr,
                          input logic [31:0] wdata, output logic [31:0] rdata,
                          output logic err, output int lat);
        @(negedge clk);
        if (port) begin
            bus.d_req = 1'b1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata;
        end else begin
            bus.if_req = 1'b1; bus.if_addr = addr;
        end
        lat = -1; rdata = '0; err = 1'b0;
        for (int n = 1; n <= 100; n++) begin
            @(negedge clk);
            if (port ? bus.d_ack : bus.if_ack) begin
                lat   = n;
                rdata = port ? bus.d_rdata : bus.if_rdata;
                err   = port ? bus.d_err : bus.if_err;
                break;
            end
        end
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lt;
    int          snap, snap2;
    int          who [4];
    int          cyc [4];
    logic [31:0] dat [4];
    int          k;

    initial begin
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0;

        #3;
        check("rst_if_ack", {31'd0, bus.if_ack}, 0);
        check("rst_d_ack", {31'd0, bus.d_ack}, 0);
        check("rst_enables", {30'd0, bus.mem_w_enable, bus.mem_r_enable}, 0);
        check("rst_mem_address", bus.mem_address, 0);
        check("rst_rdata", bus.if_rdata | bus.d_rdata, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        access(0, 0, 5, 0, rd, er, lt);
        check("fetch_lat", lt, 3);
        check("fetch_data", rd, 32'hDEADBEEF);
        check("fetch_err", {31'd0, er}, 0);
        repeat (3) @(negedge clk);
        check("fetch_hold", bus.if_rdata, 32'hDEADBEEF);

        snap = wen_cnt;
        access(1, 1, 100, 32'h12345678, rd, er, lt);
        check("write_lat", lt, 3);
        check("write_err", {31'd0, er}, 0);
        access(1, 0, 100, 0, rd, er, lt);
        check("read_back", rd, 32'h12345678);
        check("read_lat", lt, 3);
        check("write_once", wen_cnt - snap, 1);

        snap = en_cnt;
        access(1, 0, 16384, 0, rd, er, lt);
        check("range_err", {31'd0, er}, 1);
        check("range_lat", lt, 1);
        check("range_no_enable", en_cnt - snap, 0);
        access(0, 0, 16383, 0, rd, er, lt);
        check("edge_addr_ok", {31'd0, er}, 0);

        mem_lat = 1000;
        access(1, 0, 7, 0, rd, er, lt);
        check("timeout_err", {31'd0, er}, 1);
        check("timeout_lat", lt, 17);
        mem_lat = 0;
        access(1, 0, 100, 0, rd, er, lt);
        check("after_to_data", rd, 32'h12345678);
        check("after_to_err", {31'd0, er}, 0);
        check("after_to_lat", lt, 3);

        mem_lat = 2;
        access(0, 0, 5, 0, rd, er, lt);
        check("slow_lat", lt, 5);
        check("slow_data", rd, 32'hDEADBEEF);
        mem_lat = 0;

        mem_lat = 1000;
        snap = d_ack_cnt;
        @(negedge clk);
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 100;
        repeat (4) @(negedge clk);
        check("midwait_addr", bus.mem_address, 100);
        #2 rst = 1'b1;
        #1;
        check("async_d_ack", {31'd0, bus.d_ack}, 0);
        check("async_d_rdata", bus.d_rdata, 0);
        check("async_mem_address", bus.mem_address, 0);
        check("async_enables", {30'd0, bus.mem_w_enable, bus.mem_r_enable}, 0);
        repeat (2) @(negedge clk);
        bus.d_req = 1'b0;
        rst = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_no_ack", d_ack_cnt - snap, 0);
        mem_lat = 0;
        access(1, 0, 100, 0, rd, er, lt);
        check("reissue_data", rd, 32'h12345678);
        check("reissue_err", {31'd0, er}, 0);

        @(negedge clk);
        rst = 1'b1;
        bus.if_req = 1'b1; bus.if_addr = 5;
        bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 100;
        snap = if_ack_cnt; snap2 = d_ack_cnt;
        @(negedge clk);
        rst = 1'b0;
        k = 0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk);
            if (bus.if_ack || bus.d_ack) begin
                who[k] = bus.d_ack ? 1 : 0;
                cyc[k] = n;
                dat[k] = bus.d_ack ? bus.d_rdata : bus.if_rdata;
                k++;
                if (k == 4) break;
            end
        end
        bus.if_req = 1'b0; bus.d_req = 1'b0;
        check("cont_acks_seen", k, 4);
        if (k == 4) begin
            check("cont_first_owner", who[0], 1);
            check("cont_first_lat", cyc[0], 3);
            for (int i = 1; i < 4; i++) begin
                check($sformatf("cont_owner%0d", i), who[i], (i % 2 == 0) ? 1 : 0);
                check($sformatf("cont_spacing%0d", i), cyc[i] - cyc[i-1], 4);
            end
            for (int i = 0; i < 4; i++)
                check($sformatf("cont_data%0d", i), dat[i],
                      (who[i] == 1) ? 32'h12345678 : 32'hDEADBEEF);
        end
        repeat (6) @(negedge clk);
        check("cont_if_acks", if_ack_cnt - snap, 2);
        check("cont_d_acks", d_ack_cnt - snap2, 2);
        check("no_overlap", overlap_cnt, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
